// File: rtl/alu_addsub_arbiter_pkg.sv
// Shared constants for the Stage-3 add/sub arbiter: op encodings, requester IDs, default width.
// No logic here; imported by the arbiter and its adder core.
package alu_addsub_arbiter_pkg;

  localparam int ALU_N_DEFAULT = 32;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_SLT  = 2'b10;
  localparam logic [1:0] ALU_OP_SLTU = 2'b11;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/alu_addsub_arbiter_addsub.sv
// Combinational N-bit add/sub with SLT/SLTU mapping; zero latency, no flow control.
// Every op other than ADD runs the subtract path, so borrow/overflow are always for A-B there.
module addsub_core
  import alu_addsub_arbiter_pkg::*;
#(
  parameter int N = ALU_N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] res,
  output logic         borrow,
  output logic         overflow
);

  logic         sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum_ext;
  logic         slt;

  assign sub     = (op != ALU_OP_ADD);
  assign b_eff   = sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

  // Borrow is the inverted carry of A + ~B + 1.
  assign borrow   = sub & ~sum_ext[N];
  assign overflow = (a[N-1] == b_eff[N-1]) & (sum_ext[N-1] != a[N-1]);
  assign slt      = sum_ext[N-1] ^ overflow;

  always_comb begin
    res = sum_ext[N-1:0];
    case (op)
      ALU_OP_SLT:  res = {N{slt}};
      ALU_OP_SLTU: res = {N{borrow}};
      default:     res = sum_ext[N-1:0];
    endcase
  end

endmodule

// File: rtl/alu_addsub_arbiter.sv
// Two-requester arbiter over one shared add/sub; 1-cycle latency into a registered, ID-tagged output.
// READYs drop while the output is full and not drained; ALU_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module alu_addsub_arbiter
  import alu_addsub_arbiter_pkg::*;
#(
  parameter int N = ALU_N_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0_VALID,
  output logic         REQ0_READY,
  input  logic [1:0]   REQ0_OP,
  input  logic [N-1:0] REQ0_A,
  input  logic [N-1:0] REQ0_B,
  input  logic         REQ1_VALID,
  output logic         REQ1_READY,
  input  logic [1:0]   REQ1_OP,
  input  logic [N-1:0] REQ1_A,
  input  logic [N-1:0] REQ1_B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         OUT_ID,
  output logic [N-1:0] OUT_RES
);

  out_state_t   state_q, state_d;
  logic [N-1:0] out_res_q, out_res_d;
  logic         out_id_q, out_id_d;

  logic         stage_free;
  logic         prio_1;
  logic         grant_0, grant_1;
  logic         xfer;
  logic [1:0]   sel_op;
  logic [N-1:0] sel_a, sel_b;
  logic [N-1:0] core_res;
  logic         core_borrow_unused, core_ovf_unused;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign prio_1 = ptr_q;
  assign ptr_d  = xfer ? ~ptr_q : ptr_q;
`else
  assign prio_1 = 1'b0;
`endif

  assign stage_free = (state_q == OUT_EMPTY) | OUT_READY;
  assign grant_1    = REQ1_VALID & (~REQ0_VALID | prio_1);
  assign grant_0    = REQ0_VALID & ~grant_1;
  assign REQ0_READY = ~RST & stage_free & grant_0;
  assign REQ1_READY = ~RST & stage_free & grant_1;
  assign xfer       = REQ0_READY | REQ1_READY;

  assign sel_op = grant_1 ? REQ1_OP : REQ0_OP;
  assign sel_a  = grant_1 ? REQ1_A  : REQ0_A;
  assign sel_b  = grant_1 ? REQ1_B  : REQ0_B;

  addsub_core #(.N(N)) u_core (
    .a        (sel_a),
    .b        (sel_b),
    .op       (sel_op),
    .res      (core_res),
    .borrow   (core_borrow_unused),
    .overflow (core_ovf_unused)
  );

  // A drain and a new accept in the same cycle simply reload: no bubble.
  always_comb begin
    state_d   = state_q;
    out_res_d = out_res_q;
    out_id_d  = out_id_q;
    if (xfer) begin
      state_d   = OUT_FULL;
      out_res_d = core_res;
      out_id_d  = grant_1 ? REQ_ID_1 : REQ_ID_0;
    end else if ((state_q == OUT_FULL) && OUT_READY) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= OUT_EMPTY;
      out_res_q <= '0;
      out_id_q  <= REQ_ID_0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_res_q <= out_res_d;
      out_id_q  <= out_id_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign OUT_VALID = (state_q == OUT_FULL);
  assign OUT_ID    = out_id_q;
  assign OUT_RES   = out_res_q;

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Randomized self-checking bench for alu_addsub_arbiter against a transaction-level reference model.
module tb_alu_addsub_arbiter;
  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [1:0]   REQ0_OP, REQ1_OP;
  logic [N-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic         OUT_VALID, OUT_READY, OUT_ID;
  logic [N-1:0] OUT_RES;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: output register contents and number of transfers since reset.
  logic         m_full = 1'b0;
  logic [N-1:0] m_res = '0;
  logic         m_id = 1'b0;
  int           m_xfers = 0;
  logic         m_acc0 = 1'b0, m_acc1 = 1'b0;

  alu_addsub_arbiter #(.N(N)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ID(OUT_ID), .OUT_RES(OUT_RES)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N-1:0] ref_alu(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return ($signed(a) < $signed(b)) ? {N{1'b1}} : {N{1'b0}};
      default: return (a < b) ? {N{1'b1}} : {N{1'b0}};
    endcase
  endfunction

  // Which requester the spec says is accepted this cycle, or -1 for none.
  function automatic int exp_winner();
    if (RST) return -1;
    if (m_full && !OUT_READY) return -1;
    if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return m_xfers % 2;
`else
      return 0;
`endif
    end
    if (REQ0_VALID) return 0;
    if (REQ1_VALID) return 1;
    return -1;
  endfunction

  function automatic logic [N-1:0] pick_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(N-1){1'b1}}};
      2:       return {1'b1, {(N-1){1'b0}}};
      3:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  task automatic drive0(input logic v, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    REQ0_VALID = v; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    REQ1_VALID = v; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, then settle 1 time unit.
  task automatic tick();
    int w;
    w = exp_winner();
    @(posedge CLK);
    m_acc0 = (w == 0);
    m_acc1 = (w == 1);
    if (RST) begin
      m_full = 1'b0; m_res = '0; m_id = 1'b0; m_xfers = 0;
    end else if (w >= 0) begin
      m_full = 1'b1;
      m_id   = w[0];
      m_res  = (w == 0) ? ref_alu(REQ0_OP, REQ0_A, REQ0_B) : ref_alu(REQ1_OP, REQ1_A, REQ1_B);
      m_xfers++;
    end else if (m_full && OUT_READY) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; OUT_READY = 1'b1;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    drive1(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (REQ0_READY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy0[%0d]: got %b want 0", i, REQ0_READY); end
      n_cmp++; if (REQ1_READY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy1[%0d]: got %b want 0", i, REQ1_READY); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, OUT_VALID); end
      n_cmp++; if (OUT_RES !== '0) begin n_bad++; $display("FAIL reset_res[%0d]: got %h want 0", i, OUT_RES); end
      n_cmp++; if (OUT_ID !== 1'b0) begin n_bad++; $display("FAIL reset_id[%0d]: got %b want 0", i, OUT_ID); end
    end
    RST = 1'b0;
    #1;
    n_cmp++; if (REQ0_READY !== 1'b1 || REQ1_READY !== 1'b0)
      begin n_bad++; $display("FAIL first_grant: got rdy0=%b rdy1=%b want rdy0=1 rdy1=0", REQ0_READY, REQ1_READY); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_ID !== 1'b0)
      begin n_bad++; $display("FAIL first_result: got valid=%b id=%b want valid=1 id=0", OUT_VALID, OUT_ID); end
    n_cmp++; if (OUT_RES !== m_res) begin n_bad++; $display("FAIL first_res: got %h want %h", OUT_RES, m_res); end
    drive0(1'b0, 2'd0, '0, '0);
    drive1(1'b0, 2'd0, '0, '0);
    tick();
  endtask

  task automatic test_single_ops();
    logic [1:0]   ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [N-1:0] as  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [N-1:0] bs  [4] = '{32'd1, 32'd7, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [N-1:0] exp [4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    OUT_READY = 1'b1;
    drive1(1'b0, 2'd0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, ops[i], as[i], bs[i]);
      tick();
      n_cmp++; if (OUT_VALID !== 1'b1 || OUT_ID !== 1'b0)
        begin n_bad++; $display("FAIL single_tag[%0d]: got valid=%b id=%b want valid=1 id=0", i, OUT_VALID, OUT_ID); end
      n_cmp++; if (OUT_RES !== exp[i]) begin n_bad++; $display("FAIL single_res[%0d]: got %h want %h", i, OUT_RES, exp[i]); end
    end
    for (int i = 0; i < 12; i++) begin
      drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
      tick();
      n_cmp++; if (OUT_RES !== m_res) begin n_bad++; $display("FAIL single_rand[%0d]: got %h want %h", i, OUT_RES, m_res); end
    end
    drive0(1'b0, 2'd0, '0, '0);
    tick();
  endtask

  task automatic test_contention();
    int want;
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    OUT_READY = 1'b1;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    drive1(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      want = i % 2;
`else
      want = 0;
`endif
      #1;
      n_cmp++; if (REQ0_READY !== (want == 0) || REQ1_READY !== (want == 1))
        begin n_bad++; $display("FAIL contend_rdy[%0d]: got rdy0=%b rdy1=%b want winner %0d", i, REQ0_READY, REQ1_READY, want); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b1 || OUT_ID !== want[0])
        begin n_bad++; $display("FAIL contend_id[%0d]: got valid=%b id=%b want id=%0d", i, OUT_VALID, OUT_ID, want); end
      n_cmp++; if (OUT_RES !== m_res) begin n_bad++; $display("FAIL contend_res[%0d]: got %h want %h", i, OUT_RES, m_res); end
      if (m_acc0) drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
      if (m_acc1) drive1(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    end
    drive0(1'b0, 2'd0, '0, '0);
    drive1(1'b0, 2'd0, '0, '0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held_res;
    logic         held_id;
    OUT_READY = 1'b1;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    tick();
    held_res = m_res; held_id = m_id;
    OUT_READY = 1'b0;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    drive1(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0)
        begin n_bad++; $display("FAIL bp_rdy[%0d]: got rdy0=%b rdy1=%b want both 0", i, REQ0_READY, REQ1_READY); end
      tick();
      n_cmp++; if (OUT_VALID !== 1'b1 || OUT_RES !== held_res || OUT_ID !== held_id)
        begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b want v=1 res=%h id=%b", i, OUT_VALID, OUT_RES, OUT_ID, held_res, held_id); end
    end
    OUT_READY = 1'b1;
    #1;
    n_cmp++; if ((REQ0_READY | REQ1_READY) !== 1'b1)
      begin n_bad++; $display("FAIL bp_release_rdy: got rdy0=%b rdy1=%b want one high", REQ0_READY, REQ1_READY); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_RES !== m_res || OUT_ID !== m_id)
      begin n_bad++; $display("FAIL bp_release_load: got v=%b res=%h id=%b want v=1 res=%h id=%b", OUT_VALID, OUT_RES, OUT_ID, m_res, m_id); end
    drive0(1'b0, 2'd0, '0, '0);
    drive1(1'b0, 2'd0, '0, '0);
    tick();
  endtask

  task automatic test_drain();
    logic [N-1:0] stale;
    OUT_READY = 1'b1;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    tick();
    drive0(1'b0, 2'd0, '0, '0);
    stale = m_res;
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL drain_full: got %b want 1", OUT_VALID); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", OUT_VALID); end
    n_cmp++; if (OUT_RES !== stale) begin n_bad++; $display("FAIL drain_stale: got %h want %h", OUT_RES, stale); end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b0;
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    tick();
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL rmid_full: got %b want 1", OUT_VALID); end
    drive0(1'b1, 2'($urandom), pick_opnd(), pick_opnd());
    RST = 1'b1; OUT_READY = 1'b1;
    #1;
    n_cmp++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0)
      begin n_bad++; $display("FAIL rmid_rdy: got rdy0=%b rdy1=%b want both 0", REQ0_READY, REQ1_READY); end
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0 || OUT_RES !== '0)
      begin n_bad++; $display("FAIL rmid_drop: got v=%b res=%h want v=0 res=0", OUT_VALID, OUT_RES); end
    RST = 1'b0;
    drive0(1'b0, 2'd0, '0, '0);
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rmid_lost: got %b want 0", OUT_VALID); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(REQ0_VALID && !m_acc0))
        drive0(1'($urandom_range(0, 1)), 2'($urandom), pick_opnd(), pick_opnd());
      if (!(REQ1_VALID && !m_acc1))
        drive1(1'($urandom_range(0, 1)), 2'($urandom), pick_opnd(), pick_opnd());
      OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (REQ0_READY !== (exp_winner() == 0) || REQ1_READY !== (exp_winner() == 1))
        begin n_bad++; $display("FAIL rand_rdy[%0d]: got rdy0=%b rdy1=%b want winner %0d", i, REQ0_READY, REQ1_READY, exp_winner()); end
      tick();
      n_cmp++; if (OUT_VALID !== m_full || OUT_RES !== m_res || OUT_ID !== m_id)
        begin n_bad++; $display("FAIL rand_out[%0d]: got v=%b res=%h id=%b want v=%b res=%h id=%b", i, OUT_VALID, OUT_RES, OUT_ID, m_full, m_res, m_id); end
    end
  endtask

  initial begin
    RST = 1'b1; OUT_READY = 1'b0;
    drive0(1'b0, 2'd0, '0, '0);
    drive1(1'b0, 2'd0, '0, '0);
    @(negedge CLK);
    test_reset();
    test_single_ops();
    test_contention();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
